// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving six active-low seven-segment digits, with blanking,
// blinking, decimal points, a programmable tick prescaler and an optional up-counter.
module hex_display_ctrl #(
   parameter logic [31:0] DEFAULT_DIV = 32'd24999999,
   parameter int          NUM_DIGITS  = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  hex0,
   output logic [7:0]  hex1,
   output logic [7:0]  hex2,
   output logic [7:0]  hex3,
   output logic [7:0]  hex4,
   output logic [7:0]  hex5,
   output logic        tick
);

   logic [23:0]           value_q;
   logic                  en_q;
   logic                  count_en_q;
   logic [NUM_DIGITS-1:0] blank_q;
   logic [NUM_DIGITS-1:0] blink_q;
   logic [NUM_DIGITS-1:0] dp_q;
   logic [31:0]           div_q;
   logic [31:0]           cnt_q;
   logic                  phase_q;
   logic                  wrap_q;
   logic [7:0]            hex_q    [NUM_DIGITS];
   logic [7:0]            hex_next [NUM_DIGITS];

   logic wr;
   logic wr_value;
   logic wr_div;
   logic wr_status;
   logic do_incr;
   logic wrap_event;

   assign wr         = chipselect & ~write_n;
   assign wr_value   = wr & (address == 3'd0);
   assign wr_div     = wr & (address == 3'd5);
   assign wr_status  = wr & (address == 3'd6);

   // A DIV write restarts the prescaler and suppresses that cycle's tick.
   assign tick       = (cnt_q == div_q) & ~wr_div;
   assign do_incr    = count_en_q & tick & ~wr_value;
   assign wrap_event = do_incr & (value_q == 24'hFFFFFF);

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q    <= 24'd0;
         en_q       <= 1'b0;
         count_en_q <= 1'b0;
         blank_q    <= '0;
         blink_q    <= '0;
         dp_q       <= '0;
         div_q      <= DEFAULT_DIV;
         cnt_q      <= 32'd0;
         phase_q    <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         if (wr_div || tick) cnt_q <= 32'd0;
         else                cnt_q <= cnt_q + 32'd1;
         if (tick) phase_q <= ~phase_q;

         if (wr_value)     value_q <= writedata[23:0];
         else if (do_incr) value_q <= value_q + 24'd1;

         // A wrap coinciding with a software clear keeps the flag set.
         if (wrap_event)                    wrap_q <= 1'b1;
         else if (wr_status && writedata[1]) wrap_q <= 1'b0;

         if (wr && address == 3'd1) begin
            en_q       <= writedata[0];
            count_en_q <= writedata[1];
         end
         if (wr && address == 3'd2) blank_q <= writedata[NUM_DIGITS-1:0];
         if (wr && address == 3'd3) blink_q <= writedata[NUM_DIGITS-1:0];
         if (wr && address == 3'd4) dp_q    <= writedata[NUM_DIGITS-1:0];
         if (wr_div)                div_q   <= writedata;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         hex_next[i] = 8'hFF;
         if (en_q && !blank_q[i] && !(blink_q[i] && phase_q))
            hex_next[i] = {~dp_q[i], decode(value_q[4*i +: 4])};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= 8'hFF;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= hex_next[i];
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0: readdata = {8'd0, value_q};
         3'd1: readdata = {30'd0, count_en_q, en_q};
         3'd2: readdata[NUM_DIGITS-1:0] = blank_q;
         3'd3: readdata[NUM_DIGITS-1:0] = blink_q;
         3'd4: readdata[NUM_DIGITS-1:0] = dp_q;
         3'd5: readdata = div_q;
         3'd6: readdata = {30'd0, wrap_q, phase_q};
         default: readdata = 32'd0;
      endcase
   end

   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];

endmodule
